eight_ch_32bit: RTL and testbench

- 8-channel, 32-bit-per-channel data selector feeding a shared 32-bit data bus.
- The combinational output databus carries the selected channel D0..D7 in the same delta.
- A registered copy, databus_q, is provided for timing-closed downstream consumers; it is qualified by a load enable.
- Sits between eight parallel data sources and a single bus consumer.

---
 rtl/eight_ch_32bit.sv | 51 +++++
 tb/tb_eight_ch_32bit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/eight_ch_32bit.sv
// Eight-channel data selector onto a shared bus, with a combinational output
// and a load-qualified registered copy that also records the select used.
module eight_ch_32bit #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [WIDTH-1:0] databus,
    output logic [WIDTH-1:0] databus_q,
    output logic [SEL_W-1:0] sel_q
);

    // Fully decoded over all eight codes; the default line only keeps the
    // block free of latches and is overridden by every case arm.
    always_comb begin
        databus = D0;
        case (sel)
            3'd0: databus = D0;
            3'd1: databus = D1;
            3'd2: databus = D2;
            3'd3: databus = D3;
            3'd4: databus = D4;
            3'd5: databus = D5;
            3'd6: databus = D6;
            3'd7: databus = D7;
        endcase
    end

    // Registered stage: data and its select are captured on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            databus_q <= '0;
            sel_q     <= '0;
        end else if (load) begin
            databus_q <= databus;
            sel_q     <= sel;
        end
    end

endmodule

// File: tb/tb_eight_ch_32bit.sv
// Directed bench for eight_ch_32bit: combinational select, load-qualified
// capture, hold, and asynchronous reset behaviour.
module tb_eight_ch_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] d [8];
    logic [2:0]  sel;
    logic        load;
    logic [31:0] databus;
    logic [31:0] databus_q;
    logic [2:0]  sel_q;

    int n_checks;
    int n_pass;

    eight_ch_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D0        (d[0]),
        .D1        (d[1]),
        .D2        (d[2]),
        .D3        (d[3]),
        .D4        (d[4]),
        .D5        (d[5]),
        .D6        (d[6]),
        .D7        (d[7]),
        .sel       (sel),
        .load      (load),
        .databus   (databus),
        .databus_q (databus_q),
        .sel_q     (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic set_d(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7);
        d[0] = 32'(v0); d[1] = 32'(v1); d[2] = 32'(v2); d[3] = 32'(v3);
        d[4] = 32'(v4); d[5] = 32'(v5); d[6] = 32'(v6); d[7] = 32'(v7);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b1;
        load  = 1'b0;
        sel   = 3'd0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with all-zero inputs
        #2 rst_n = 1'b0;
        #1;
        check("rst_databus", databus, 32'd0);
        check("rst_databus_q", databus_q, 32'd0);
        check("rst_sel_q", {29'd0, sel_q}, 32'd0);

        // Reset overrides load; databus still tracks inputs
        d[5] = 32'd5;
        sel  = 3'd5;
        load = 1'b1;
        @(posedge clk); #1;
        check("rst_comb_live", databus, 32'd5);
        check("rst_over_load_q", databus_q, 32'd0);
        check("rst_over_load_sel", {29'd0, sel_q}, 32'd0);

        // Release reset; no load -> outputs stay zero
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_rst_q", databus_q, 32'd0);
        check("post_rst_sel", {29'd0, sel_q}, 32'd0);

        // Combinational select
        @(negedge clk);
        set_d(13, 45, 28, 75, 99, 33, 59, 73);
        sel = 3'd1; #1;
        check("comb_sel1", databus, 32'd45);
        sel = 3'd7; #1;
        check("comb_sel7", databus, 32'd73);

        // Capture on a single load pulse, then hold
        set_d(63, 35, 74, 25, 18, 37, 49, 83);
        sel = 3'd3; #1;
        check("comb_sel3", databus, 32'd25);
        @(negedge clk);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("load_q", databus_q, 32'd25);
        check("load_sel_q", {29'd0, sel_q}, 32'd3);
        sel = 3'd5;
        @(posedge clk); #1;
        check("hold_comb", databus, 32'd37);
        check("hold_q", databus_q, 32'd25);
        check("hold_sel_q", {29'd0, sel_q}, 32'd3);

        @(negedge clk);
        set_d(27, 18, 34, 49, 59, 65, 89, 73);
        sel = 3'd4; #1;
        check("comb_sel4", databus, 32'd59);
        set_d(29, 65, 54, 65, 14, 85, 71, 46);
        sel = 3'd6; #1;
        check("comb_sel6", databus, 32'd71);

        // Sweep all select codes with full-width data
        @(negedge clk);
        for (int n = 0; n < 8; n++) d[n] = 32'hFFFF_FFF0 + 32'(n);
        load = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            sel = 3'(n);
            #1;
            check($sformatf("sweep_comb%0d", n), databus, 32'hFFFF_FFF0 + 32'(n));
            @(posedge clk); #1;
            check($sformatf("sweep_q%0d", n), databus_q, 32'hFFFF_FFF0 + 32'(n));
            check($sformatf("sweep_sel%0d", n), {29'd0, sel_q}, 32'(n));
        end

        // Mid-cycle asynchronous reset
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", databus_q, 32'd0);
        check("async_rst_sel", {29'd0, sel_q}, 32'd0);
        check("async_rst_comb", databus, 32'hFFFF_FFF7);

        // First capture after release
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b1;
        sel   = 3'd2;
        @(posedge clk); #1;
        load = 1'b0;
        check("relcap_q", databus_q, 32'hFFFF_FFF2);
        check("relcap_sel", {29'd0, sel_q}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
